psum_accum_buffer: RTL and testbench
====================================

Name: psum_accum_buffer

Overview:
- Parametrised successor to the single-lane output/psum buffering path of the conv accelerator top.
- Sits between the PE array output and the host-side output buffer. Combines PE partial sums with externally supplied partial sums from a previous tile.
- Generalised to NUM_CH parallel lanes, configurable depth, and three combine modes.
- Adds backpressure, count and overflow reporting that the current buffer does not have.

Parameters:
- DATA_WIDTH, 32, width of one psum lane (signed two's complement).
- NUM_CH, 1, number of parallel lanes per entry.
- DEPTH, 64, entries in each internal FIFO; must be a power of two, 4 or more.
- PTR_LEN, $clog2(DEPTH), pointer width (derived; do not override).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- calc_mod  in  2  combine mode: 00 PASS, 01 ACCUM, 10 JUST_ADD, 11 reserved (treated as PASS).
- pe_valid  in  1  PE result valid.
- pe_din  in  NUM_CH*DATA_WIDTH  PE results; lane k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- pe_ready  out  1  block accepts pe_din this cycle.
- psum_buf_wen  in  1  push external psum entry.
- P_sum_buff_inp  in  NUM_CH*DATA_WIDTH  external psum entry.
- psum_full  out  1  external psum FIFO full.
- psum_empty  out  1  external psum FIFO empty.
- outbuf_ren  in  1  pop output entry.
- outbuf_dout  out  NUM_CH*DATA_WIDTH  registered read data.
- outbuf_full  out  1  output FIFO full.
- outbuf_empty  out  1  output FIFO empty.
- outbuf_count  out  PTR_LEN+1  output FIFO occupancy.
- overflow_err  out  1  sticky: write attempted to a full FIFO.

Behaviour:
- Reset (rst=1 at an edge): both FIFOs emptied, stage register invalid, outbuf_dout=0, overflow_err=0, outbuf_count=0, full flags 0, empty flags 1. Reset mid-operation discards all in-flight data.
- External psum FIFO: psum_buf_wen while !psum_full writes at the edge. When full, the write is dropped and overflow_err is set.
- One combine stage register (stage_valid, stage_data) sits between the inputs and the output FIFO.
- stage_drain = stage_valid && (!outbuf_full || outbuf_ren). The stage writes into the output FIFO on drain. Simultaneous read and write when full is legal and keeps the count unchanged.
- slot_free = !stage_valid || stage_drain.
- PASS:
  - pe_ready = slot_free.
  - stage_data = pe_din.
  - The external FIFO is untouched.
- ACCUM:
  - pe_ready = slot_free && !psum_empty.
  - On handshake, one external entry is popped and each lane computes stage_data[k] = pe_din[k] + psum[k], modulo 2^DATA_WIDTH.
- JUST_ADD:
  - pe_ready = 0.
  - Whenever slot_free && !psum_empty, one external entry is popped and copied into the stage unchanged.
- calc_mod is sampled per transfer; an entry already in the stage is not affected by a mode change.
- Latency: handshake at edge N; entry written to the output FIFO at edge N+1 (if not full); outbuf_empty falls after edge N+1.
- Read: outbuf_ren && !outbuf_empty pops; outbuf_dout updates at that edge and holds otherwise. Reading an empty FIFO is ignored (no error, dout held).
- pe_valid && !pe_ready: data is not taken; the source must hold.
- Pointers wrap modulo DEPTH. Full/empty are derived from the PTR_LEN+1-bit count.

Optional Feature:
- Macro PSUM_SAT_EN.
- Defined: the ACCUM add is signed saturating per lane, clamping to 2^(DATA_WIDTH-1)-1 and -2^(DATA_WIDTH-1). An extra sticky output sat_flag (1 bit, reset 0) is set on any clamp.
- Undefined: the add wraps and the sat_flag port does not exist.

Decomposition:
- Package psum_pkg: mode constants (MODE_PASS, MODE_ACCUM, MODE_JUST_ADD), function lane_add(a, b) with an optional saturation branch.
- Sub-module sync_fifo (params WIDTH, DEPTH): registered read, count, full/empty. Instantiated twice, once for the external psum FIFO and once for the output FIFO. Combine stage and handshake logic stay in the top.

Test Plan:
- Reset then PASS, NUM_CH=1: push pe_din 5, 7, -3 on consecutive cycles, then pop three times -> outbuf_dout 5, 7, -3 in order; outbuf_empty low one edge after the first handshake.
- ACCUM: push external 1, 2; offer pe 10, 20, 30 -> first two accepted, third stalls with pe_ready=0 while psum_empty=1; output 11, 22.
- JUST_ADD with pe_valid held high: external 100, -4 -> output 100, -4; pe_ready stays 0 throughout.
- DEPTH=4, no reads: push 6 PE entries -> outbuf_full after the 4th write plus one held in the stage; pe_ready=0. Read and write in the same cycle -> outbuf_count stays 4. Push 5 external entries while full -> overflow_err=1.
- NUM_CH=4, DATA_WIDTH=16, ACCUM, 0x7FFF+1 in lane 2 -> without PSUM_SAT_EN lane 2 = 0x8000; with PSUM_SAT_EN lane 2 = 0x7FFF and sat_flag=1; other lanes unaffected.
- Assert rst while entries are queued -> next cycle outbuf_empty=1, psum_empty=1, outbuf_dout=0, overflow_err=0.

Source files
------------

// File: rtl/psum_pkg.sv
// Shared mode encoding and lane arithmetic for the psum accumulation buffer.
// PSUM_SAT_EN selects saturating instead of wrapping lane addition.
package psum_pkg;

  typedef enum logic [1:0] {
    MODE_PASS     = 2'b00,
    MODE_ACCUM    = 2'b01,
    MODE_JUST_ADD = 2'b10,
    MODE_RSVD     = 2'b11
  } calc_mode_e;

  // Operands arrive left-aligned (lane MSB at bit 63) so one 64-bit add
  // serves every DATA_WIDTH, and signed overflow shows up in bit 63.
  function automatic logic [63:0] lane_add(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] s;
    s = a + b;
`ifdef PSUM_SAT_EN
    if ((a[63] == b[63]) && (s[63] != a[63])) begin
      s = a[63] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
    end else begin
      s = s;
    end
`endif
    return s;
  endfunction

`ifdef PSUM_SAT_EN
  function automatic logic lane_sat_hit(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] s;
    s = a + b;
    return (a[63] == b[63]) && (s[63] != a[63]);
  endfunction
`endif

endpackage

// File: rtl/psum_accum_buffer_if.sv
// Bus bundle between the psum accumulation buffer and its surroundings.
// sat_flag exists only when PSUM_SAT_EN is defined.
interface psum_accum_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 1,
  parameter int DEPTH      = 64
);
  localparam int PTR_LEN = $clog2(DEPTH);

  logic [1:0]                   calc_mod;
  logic                         pe_valid;
  logic [NUM_CH*DATA_WIDTH-1:0] pe_din;
  logic                         pe_ready;
  logic                         psum_buf_wen;
  logic [NUM_CH*DATA_WIDTH-1:0] P_sum_buff_inp;
  logic                         psum_full;
  logic                         psum_empty;
  logic                         outbuf_ren;
  logic [NUM_CH*DATA_WIDTH-1:0] outbuf_dout;
  logic                         outbuf_full;
  logic                         outbuf_empty;
  logic [PTR_LEN:0]             outbuf_count;
  logic                         overflow_err;
`ifdef PSUM_SAT_EN
  logic                         sat_flag;
`endif

  modport master (
    output calc_mod, pe_valid, pe_din, psum_buf_wen, P_sum_buff_inp, outbuf_ren,
    input  pe_ready, psum_full, psum_empty, outbuf_dout, outbuf_full, outbuf_empty,
    input  outbuf_count, overflow_err
`ifdef PSUM_SAT_EN
    , input sat_flag
`endif
  );

  modport slave (
    input  calc_mod, pe_valid, pe_din, psum_buf_wen, P_sum_buff_inp, outbuf_ren,
    output pe_ready, psum_full, psum_empty, outbuf_dout, outbuf_full, outbuf_empty,
    output outbuf_count, overflow_err
`ifdef PSUM_SAT_EN
    , output sat_flag
`endif
  );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; FWFT=1 exposes the head word
// combinationally, FWFT=0 gives a registered read port that holds between pops.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  parameter bit FWFT  = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_INC  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_INC  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_wr_s;
  logic             do_rd_s;

  assign full    = (count_r == CNT_FULL);
  assign empty   = (count_r == {(AW+1){1'b0}});
  assign count   = count_r;
  assign do_rd_s = rd_en && !empty;
  assign do_wr_s = wr_en && (!full || do_rd_s);

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_wr_s) wr_ptr_r <= wr_ptr_r + PTR_INC;
      if (do_rd_s) rd_ptr_r <= rd_ptr_r + PTR_INC;
      case ({do_wr_s, do_rd_s})
        2'b10:   count_r <= count_r + CNT_INC;
        2'b01:   count_r <= count_r - CNT_INC;
        default: count_r <= count_r;
      endcase
    end
  end

  if (FWFT) begin : g_fwft
    assign rd_data = mem_r[rd_ptr_r];
  end else begin : g_reg
    logic [WIDTH-1:0] dout_r;
    // Registered read data, held until the next successful pop.
    always_ff @(posedge clk) begin
      if (rst) begin
        dout_r <= {WIDTH{1'b0}};
      end else if (do_rd_s) begin
        dout_r <= mem_r[rd_ptr_r];
      end else begin
        dout_r <= dout_r;
      end
    end
    assign rd_data = dout_r;
  end

endmodule

// File: rtl/psum_accum_buffer.sv
// Combines PE partial sums with previous-tile psums through one stage register
// into an output FIFO. PSUM_SAT_EN: saturating ACCUM add plus sticky sat_flag.
module psum_accum_buffer
  import psum_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 1,
  parameter int DEPTH      = 64,
  parameter int PTR_LEN    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  psum_accum_buffer_if.slave io
);
  localparam int W = NUM_CH * DATA_WIDTH;

  calc_mode_e       mode_s;
  logic             stage_valid_r;
  logic [W-1:0]     stage_data_r;
  logic             stage_drain_s;
  logic             slot_free_s;
  logic             pe_ready_s;
  logic             psum_pop_s;
  logic             load_s;
  logic [W-1:0]     load_data_s;
  logic [W-1:0]     psum_head_s;
  logic             psum_full_s;
  logic             psum_wr_s;
  logic             psum_avail_s;
  logic [PTR_LEN:0] psum_count_s;
  logic             out_full_s;
  logic             overflow_err_r;
`ifdef PSUM_SAT_EN
  logic             clamp_s;
  logic             sat_flag_r;
`endif

  assign mode_s        = calc_mode_e'(io.calc_mod);
  assign psum_avail_s  = (psum_count_s != {(PTR_LEN+1){1'b0}});
  assign psum_wr_s     = io.psum_buf_wen && !psum_full_s;
  assign stage_drain_s = stage_valid_r && (!out_full_s || io.outbuf_ren);
  assign slot_free_s   = !stage_valid_r || stage_drain_s;

  // Mode-dependent handshake and the value entering the stage.
  always_comb begin
    pe_ready_s  = 1'b0;
    psum_pop_s  = 1'b0;
    load_s      = 1'b0;
    load_data_s = io.pe_din;
`ifdef PSUM_SAT_EN
    clamp_s     = 1'b0;
`endif
    case (mode_s)
      MODE_ACCUM: begin
        pe_ready_s = slot_free_s && psum_avail_s;
        load_s     = io.pe_valid && pe_ready_s;
        psum_pop_s = load_s;
        for (int k = 0; k < NUM_CH; k++) begin
          load_data_s[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(lane_add(
              64'(io.pe_din[k*DATA_WIDTH +: DATA_WIDTH]) << (64 - DATA_WIDTH),
              64'(psum_head_s[k*DATA_WIDTH +: DATA_WIDTH]) << (64 - DATA_WIDTH)) >> (64 - DATA_WIDTH));
`ifdef PSUM_SAT_EN
          clamp_s = clamp_s | lane_sat_hit(
              64'(io.pe_din[k*DATA_WIDTH +: DATA_WIDTH]) << (64 - DATA_WIDTH),
              64'(psum_head_s[k*DATA_WIDTH +: DATA_WIDTH]) << (64 - DATA_WIDTH));
`endif
        end
      end
      MODE_JUST_ADD: begin
        load_s      = slot_free_s && psum_avail_s;
        psum_pop_s  = load_s;
        load_data_s = psum_head_s;
      end
      default: begin
        pe_ready_s = slot_free_s;
        load_s     = io.pe_valid && slot_free_s;
      end
    endcase
  end

  // Combine stage: a new load may coincide with the old entry draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid_r <= 1'b0;
      stage_data_r  <= {W{1'b0}};
    end else if (load_s) begin
      stage_valid_r <= 1'b1;
      stage_data_r  <= load_data_s;
    end else if (stage_drain_s) begin
      stage_valid_r <= 1'b0;
    end else begin
      stage_valid_r <= stage_valid_r;
    end
  end

  // Sticky status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_err_r <= 1'b0;
`ifdef PSUM_SAT_EN
      sat_flag_r     <= 1'b0;
`endif
    end else begin
      if (io.psum_buf_wen && psum_full_s) overflow_err_r <= 1'b1;
`ifdef PSUM_SAT_EN
      if (load_s && (mode_s == MODE_ACCUM) && clamp_s) sat_flag_r <= 1'b1;
`endif
    end
  end

  sync_fifo #(.WIDTH(W), .DEPTH(DEPTH), .FWFT(1'b1)) u_psum_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (psum_wr_s),
    .wr_data (io.P_sum_buff_inp),
    .rd_en   (psum_pop_s),
    .rd_data (psum_head_s),
    .full    (psum_full_s),
    .empty   (io.psum_empty),
    .count   (psum_count_s)
  );

  sync_fifo #(.WIDTH(W), .DEPTH(DEPTH), .FWFT(1'b0)) u_out_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (stage_drain_s),
    .wr_data (stage_data_r),
    .rd_en   (io.outbuf_ren),
    .rd_data (io.outbuf_dout),
    .full    (out_full_s),
    .empty   (io.outbuf_empty),
    .count   (io.outbuf_count)
  );

  assign io.pe_ready     = pe_ready_s;
  assign io.psum_full    = psum_full_s;
  assign io.outbuf_full  = out_full_s;
  assign io.overflow_err = overflow_err_r;
`ifdef PSUM_SAT_EN
  assign io.sat_flag     = sat_flag_r;
`endif

endmodule

// File: tb/tb_psum_accum_buffer.sv
// Directed bench: a single-lane DEPTH=4 instance for modes, fill and reset,
// and a four-lane 16-bit instance for lane arithmetic (PSUM_SAT_EN aware).
module tb_psum_accum_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  psum_accum_buffer_if #(.DATA_WIDTH(32), .NUM_CH(1), .DEPTH(4)) ia ();
  psum_accum_buffer_if #(.DATA_WIDTH(16), .NUM_CH(4), .DEPTH(4)) ib ();

  psum_accum_buffer #(.DATA_WIDTH(32), .NUM_CH(1), .DEPTH(4)) dut_a (.clk(clk), .rst(rst), .io(ia));
  psum_accum_buffer #(.DATA_WIDTH(16), .NUM_CH(4), .DEPTH(4)) dut_b (.clk(clk), .rst(rst), .io(ib));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic        pv;
    logic [31:0] pd;
    logic        pw;
    logic [31:0] pdin;
    logic        ren;
    logic        ex_ready;
    logic        ex_oempty;
    logic        ex_pempty;
    logic [31:0] ex_dout;
    logic [2:0]  ex_count;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] mode, input logic pv, input logic [31:0] pd,
                              input logic pw, input logic [31:0] pdin, input logic ren,
                              input logic rdy, input logic oe, input logic pe,
                              input logic [31:0] dout, input logic [2:0] cnt);
    vec_t v;
    v = '{mode, pv, pd, pw, pdin, ren, rdy, oe, pe, dout, cnt};
    return v;
  endfunction

  localparam logic [1:0] P = 2'b00, A = 2'b01, J = 2'b10;
  vec_t vecs[22];

  logic [63:0] e1_psum, e1_pe, e1_exp, e2_psum, e2_pe, e2_exp;
  int sent;

  initial begin
    // columns: mode pv pd pw pdin ren | ready oempty pempty dout count
    vecs[0]  = mk(P, 1'b1, 32'd5,          1'b0, 32'd0,          1'b0, 1'b1, 1'b1, 1'b1, 32'd0,          3'd0);
    vecs[1]  = mk(P, 1'b1, 32'd7,          1'b0, 32'd0,          1'b0, 1'b1, 1'b1, 1'b1, 32'd0,          3'd0);
    vecs[2]  = mk(P, 1'b1, 32'hFFFF_FFFD,  1'b0, 32'd0,          1'b0, 1'b1, 1'b0, 1'b1, 32'd0,          3'd1);
    vecs[3]  = mk(P, 1'b0, 32'd0,          1'b0, 32'd0,          1'b1, 1'b1, 1'b0, 1'b1, 32'd0,          3'd2);
    vecs[4]  = mk(P, 1'b0, 32'd0,          1'b0, 32'd0,          1'b1, 1'b1, 1'b0, 1'b1, 32'd5,          3'd2);
    vecs[5]  = mk(P, 1'b0, 32'd0,          1'b0, 32'd0,          1'b1, 1'b1, 1'b0, 1'b1, 32'd7,          3'd1);
    vecs[6]  = mk(P, 1'b0, 32'd0,          1'b0, 32'd0,          1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFD,  3'd0);
    vecs[7]  = mk(A, 1'b1, 32'd10,         1'b1, 32'd1,          1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFD,  3'd0);
    vecs[8]  = mk(A, 1'b1, 32'd10,         1'b1, 32'd2,          1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFD,  3'd0);
    vecs[9]  = mk(A, 1'b1, 32'd20,         1'b0, 32'd0,          1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFD,  3'd0);
    vecs[10] = mk(A, 1'b1, 32'd30,         1'b0, 32'd0,          1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFD,  3'd1);
    vecs[11] = mk(A, 1'b1, 32'd30,         1'b0, 32'd0,          1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFD,  3'd2);
    vecs[12] = mk(A, 1'b0, 32'd0,          1'b0, 32'd0,          1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFD,  3'd2);
    vecs[13] = mk(A, 1'b0, 32'd0,          1'b0, 32'd0,          1'b1, 1'b0, 1'b0, 1'b1, 32'd11,         3'd1);
    vecs[14] = mk(A, 1'b0, 32'd0,          1'b0, 32'd0,          1'b0, 1'b0, 1'b1, 1'b1, 32'd22,         3'd0);
    vecs[15] = mk(J, 1'b1, 32'd999,        1'b1, 32'd100,        1'b0, 1'b0, 1'b1, 1'b1, 32'd22,         3'd0);
    vecs[16] = mk(J, 1'b1, 32'd999,        1'b1, 32'hFFFF_FFFC,  1'b0, 1'b0, 1'b1, 1'b0, 32'd22,         3'd0);
    vecs[17] = mk(J, 1'b1, 32'd999,        1'b0, 32'd0,          1'b0, 1'b0, 1'b1, 1'b0, 32'd22,         3'd0);
    vecs[18] = mk(J, 1'b1, 32'd999,        1'b0, 32'd0,          1'b0, 1'b0, 1'b0, 1'b1, 32'd22,         3'd1);
    vecs[19] = mk(J, 1'b1, 32'd999,        1'b0, 32'd0,          1'b1, 1'b0, 1'b0, 1'b1, 32'd22,         3'd2);
    vecs[20] = mk(J, 1'b1, 32'd999,        1'b0, 32'd0,          1'b1, 1'b0, 1'b0, 1'b1, 32'd100,        3'd1);
    vecs[21] = mk(P, 1'b0, 32'd0,          1'b0, 32'd0,          1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC,  3'd0);

    {ia.calc_mod, ia.pe_valid, ia.pe_din, ia.psum_buf_wen, ia.P_sum_buff_inp, ia.outbuf_ren} = '0;
    {ib.calc_mod, ib.pe_valid, ib.pe_din, ib.psum_buf_wen, ib.P_sum_buff_inp, ib.outbuf_ren} = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_oempty", 64'(ia.outbuf_empty), 64'd1);
    chk("reset_pempty", 64'(ia.psum_empty), 64'd1);
    chk("reset_full", 64'({ia.outbuf_full, ia.psum_full}), 64'd0);
    chk("reset_count", 64'(ia.outbuf_count), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      ia.calc_mod = vecs[i].mode;   ia.pe_valid = vecs[i].pv;     ia.pe_din = vecs[i].pd;
      ia.psum_buf_wen = vecs[i].pw; ia.P_sum_buff_inp = vecs[i].pdin; ia.outbuf_ren = vecs[i].ren;
      #1;
      chk($sformatf("v%0d_ready", i),  64'(ia.pe_ready),     64'(vecs[i].ex_ready));
      chk($sformatf("v%0d_oempty", i), 64'(ia.outbuf_empty), 64'(vecs[i].ex_oempty));
      chk($sformatf("v%0d_pempty", i), 64'(ia.psum_empty),   64'(vecs[i].ex_pempty));
      chk($sformatf("v%0d_dout", i),   64'(ia.outbuf_dout),  64'(vecs[i].ex_dout));
      chk($sformatf("v%0d_count", i),  64'(ia.outbuf_count), 64'(vecs[i].ex_count));
    end

    // Fill: 4 in the output FIFO plus 1 in the stage, then backpressure.
    sent = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      ia.calc_mod = P; ia.outbuf_ren = 1'b0; ia.psum_buf_wen = 1'b0;
      ia.pe_valid = 1'b1; ia.pe_din = 32'(200 + sent);
      #1;
      if (ia.pe_ready) sent++;
    end
    chk("fill_accepted", 64'(sent), 64'd5);
    @(negedge clk);
    #1;
    chk("fill_full", 64'(ia.outbuf_full), 64'd1);
    chk("fill_count", 64'(ia.outbuf_count), 64'd4);
    chk("fill_ready_stall", 64'(ia.pe_ready), 64'd0);
    ia.outbuf_ren = 1'b1;
    #1;
    chk("rdwr_ready", 64'(ia.pe_ready), 64'd1);
    @(negedge clk);
    ia.outbuf_ren = 1'b0; ia.pe_valid = 1'b0;
    #1;
    chk("rdwr_count", 64'(ia.outbuf_count), 64'd4);
    chk("rdwr_dout", 64'(ia.outbuf_dout), 64'd200);
    chk("rdwr_full", 64'(ia.outbuf_full), 64'd1);

    // Overflow: fifth external push into a DEPTH=4 FIFO.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ia.psum_buf_wen = 1'b1; ia.P_sum_buff_inp = 32'(i);
      #1;
      if (i == 4) begin
        chk("ovf_before", 64'(ia.overflow_err), 64'd0);
        chk("ovf_pfull", 64'(ia.psum_full), 64'd1);
      end
    end
    @(negedge clk);
    ia.psum_buf_wen = 1'b0;
    #1;
    chk("ovf_sticky", 64'(ia.overflow_err), 64'd1);

    // Reset with both FIFOs loaded.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_oempty", 64'(ia.outbuf_empty), 64'd1);
    chk("rst_pempty", 64'(ia.psum_empty), 64'd1);
    chk("rst_dout", 64'(ia.outbuf_dout), 64'd0);
    chk("rst_ovf", 64'(ia.overflow_err), 64'd0);
    chk("rst_count", 64'(ia.outbuf_count), 64'd0);

    // Four-lane ACCUM: lane 2 positive overflow, then lane 0 negative overflow.
    e1_psum = {16'h0004, 16'h0001, 16'hFFFF, 16'h0003};
    e1_pe   = {16'h0010, 16'h7FFF, 16'h0001, 16'h1234};
    e2_psum = {16'h0000, 16'h0000, 16'h0000, 16'hFFFF};
    e2_pe   = {16'h0000, 16'h0000, 16'h0000, 16'h8000};
`ifdef PSUM_SAT_EN
    e1_exp  = {16'h0014, 16'h7FFF, 16'h0000, 16'h1237};
    e2_exp  = {16'h0000, 16'h0000, 16'h0000, 16'h8000};
`else
    e1_exp  = {16'h0014, 16'h8000, 16'h0000, 16'h1237};
    e2_exp  = {16'h0000, 16'h0000, 16'h0000, 16'h7FFF};
`endif
    @(negedge clk);
    ib.calc_mod = A; ib.psum_buf_wen = 1'b1; ib.P_sum_buff_inp = e1_psum;
    @(negedge clk);
    ib.P_sum_buff_inp = e2_psum; ib.pe_valid = 1'b1; ib.pe_din = e1_pe;
    #1;
    chk("b_ready1", 64'(ib.pe_ready), 64'd1);
`ifdef PSUM_SAT_EN
    chk("b_sat_before", 64'(ib.sat_flag), 64'd0);
`endif
    @(negedge clk);
    ib.psum_buf_wen = 1'b0; ib.pe_din = e2_pe;
    #1;
    chk("b_ready2", 64'(ib.pe_ready), 64'd1);
`ifdef PSUM_SAT_EN
    chk("b_sat_after", 64'(ib.sat_flag), 64'd1);
`endif
    @(negedge clk);
    ib.pe_valid = 1'b0;
    @(negedge clk);
    ib.outbuf_ren = 1'b1;
    @(negedge clk);
    #1;
    chk("b_lanes1", ib.outbuf_dout, e1_exp);
    @(negedge clk);
    ib.outbuf_ren = 1'b0;
    #1;
    chk("b_lanes2", ib.outbuf_dout, e2_exp);
    chk("b_empty", 64'(ib.outbuf_empty), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
